// File: rtl/tt_um_uwasic_onboarding_eva_jin_core.sv
// SPI-configured 16-channel output block: write-only register file driving
// per-channel enable / PWM-select, with a shared ~3 kHz PWM generator.
module tt_um_uwasic_onboarding_eva_jin_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int unsigned FRAME_W   = 16;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CH_W      = 16;
    localparam int unsigned PRESC_W   = 4;
    localparam int unsigned PRESC_MAX = 12;
    localparam int unsigned MAX_ADDR  = 4;

    typedef enum logic {
        S_IDLE,
        S_RECV
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           sclk_q, copi_q, ncs_q;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 commit_c;
    logic                 sclk_rise_c, ncs_rise_c, ncs_fall_c;
    logic [CH_W-1:0]      en_out_q, en_pwm_q, out_q;
    logic [DATA_W-1:0]    duty_q, period_q;
    logic [PRESC_W-1:0]   presc_q;
    logic                 pwm_c;
    logic [CH_W-1:0]      out_c;
    logic [ADDR_W-1:0]    addr_c;
    logic                 unused_inputs;

    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

    // Bits [1:0] form the synchronizer; bit [2] holds the previous synchronized value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            copi_q <= '0;
            ncs_q  <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], ui_in[0]};
            copi_q <= {copi_q[1:0], ui_in[1]};
            ncs_q  <= {ncs_q[1:0], ui_in[2]};
        end
    end

    assign sclk_rise_c = sclk_q[1] & ~sclk_q[2];
    assign ncs_rise_c  = ncs_q[1] & ~ncs_q[2];
    assign ncs_fall_c  = ~ncs_q[1] & ncs_q[2];
    assign addr_c      = shift_q[14:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only a falling nCS arms reception, so a frame in flight across reset is ignored.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ncs_fall_c) begin
                    state_d = S_RECV;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            S_RECV: begin
                if (ncs_rise_c) begin
                    state_d  = S_IDLE;
                    commit_c = (cnt_q == CNT_W'(FRAME_W)) && shift_q[15]
                               && (addr_c <= ADDR_W'(MAX_ADDR));
                end else if (sclk_rise_c) begin
                    // Counter saturates one past a full frame so overlong frames are rejected.
                    if (cnt_q < CNT_W'(FRAME_W)) begin
                        shift_d = {shift_q[FRAME_W-2:0], copi_q[1]};
                    end
                    if (cnt_q <= CNT_W'(FRAME_W)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out_q <= '0;
            en_pwm_q <= '0;
            duty_q   <= '0;
        end else if (commit_c) begin
            case (addr_c)
                7'h00:   en_out_q[7:0]  <= shift_q[7:0];
                7'h01:   en_out_q[15:8] <= shift_q[7:0];
                7'h02:   en_pwm_q[7:0]  <= shift_q[7:0];
                7'h03:   en_pwm_q[15:8] <= shift_q[7:0];
                7'h04:   duty_q         <= shift_q[7:0];
                default: ;
            endcase
        end
    end

    // Divide-by-13 prescaler advancing a free-running 8-bit period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            period_q <= '0;
        end else if (presc_q == PRESC_W'(PRESC_MAX)) begin
            presc_q  <= '0;
            period_q <= period_q + DATA_W'(1);
        end else begin
            presc_q  <= presc_q + PRESC_W'(1);
        end
    end

    assign pwm_c = (duty_q == 8'hFF) || (period_q < duty_q);
    assign out_c = en_out_q & (~en_pwm_q | {CH_W{pwm_c}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_c;
        end
    end

    assign uo_out  = out_q[7:0];
    assign uio_out = out_q[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_eva_jin_core.sv
// Directed bench: table of SPI frames with expected outputs, plus reset and PWM sequences.
module tb_tt_um_uwasic_onboarding_eva_jin_core;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic [7:0]  exp_uo;
        logic [7:0]  exp_uio;
    } vec_t;

    vec_t vecs[14];

    tt_um_uwasic_onboarding_eva_jin_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic spi_start();
        @(negedge clk);
        ui_in[2] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [15:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            ui_in[1] = data[15-i];
            repeat (3) @(negedge clk);
            ui_in[0] = 1'b1;
            repeat (4) @(negedge clk);
            ui_in[0] = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic spi_end();
        ui_in[2] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [15:0] data, input int n);
        spi_start();
        spi_bits(data, n);
        spi_end();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int  cyc;
        int  hi;
        int  lo;
        int  cnt;
        logic found;
        logic prev;

        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'h04;
        rst_n  = 1'b0;

        vecs[0]  = '{16'h80F0, 16, 8'hF0, 8'h00};
        vecs[1]  = '{16'h81CC, 16, 8'hF0, 8'hCC};
        vecs[2]  = '{16'h0130, 16, 8'hF0, 8'hCC};
        vecs[3]  = '{16'h85AA, 16, 8'hF0, 8'hCC};
        vecs[4]  = '{16'hFF55, 16, 8'hF0, 8'hCC};
        vecs[5]  = '{16'h800F, 12, 8'hF0, 8'hCC};
        vecs[6]  = '{16'h8033, 16, 8'h33, 8'hCC};
        vecs[7]  = '{16'h8100, 16, 8'h33, 8'h00};
        vecs[8]  = '{16'h8312, 16, 8'h33, 8'h00};
        vecs[9]  = '{16'h81FF, 16, 8'h33, 8'hED};
        vecs[10] = '{16'h84FF, 16, 8'h33, 8'hFF};
        vecs[11] = '{16'h8400, 16, 8'h33, 8'hED};
        vecs[12] = '{16'h8233, 16, 8'h00, 8'hED};
        vecs[13] = '{16'h84FF, 16, 8'h33, 8'hFF};

        repeat (3) @(negedge clk);
        check("reset_uo", 32'(uo_out), 32'h00);
        check("reset_uio", 32'(uio_out), 32'h00);
        check("reset_oe", 32'(uio_oe), 32'hFF);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_uo", 32'(uo_out), 32'h00);

        for (int v = 0; v < 14; v++) begin
            spi_frame(vecs[v].frame, vecs[v].nbits);
            check($sformatf("vec%0d_uo", v), 32'(uo_out), 32'(vecs[v].exp_uo));
            check($sformatf("vec%0d_uio", v), 32'(uio_out), 32'(vecs[v].exp_uio));
        end

        // Asynchronous reset with everything configured
        @(negedge clk);
        #20;
        rst_n = 1'b0;
        #1;
        check("async_rst_uo", 32'(uo_out), 32'h00);
        check("async_rst_uio", 32'(uio_out), 32'h00);
        check("async_rst_oe", 32'(uio_oe), 32'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("after_rst_uo", 32'(uo_out), 32'h00);
        check("after_rst_uio", 32'(uio_out), 32'h00);

        // Reset mid-frame; a full frame clocked after release without a new nCS fall is dropped
        spi_start();
        spi_bits(16'h80F0, 8);
        rst_n = 1'b0;
        #1;
        check("midframe_rst_uo", 32'(uo_out), 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_bits(16'h80F0, 16);
        spi_end();
        check("no_fresh_fall_uo", 32'(uo_out), 32'h00);
        spi_frame(16'h80A5, 16);
        check("fresh_frame_uo", 32'(uo_out), 32'hA5);

        // PWM 50%: channel 0 only
        do_reset();
        spi_frame(16'h8001, 16);
        spi_frame(16'h8201, 16);
        spi_frame(16'h8480, 16);
        cyc = 0;
        found = 1'b0;
        prev = uo_out[0];
        while (cyc < 5000 && !found) begin
            @(negedge clk);
            cyc++;
            if (uo_out[0] && !prev) found = 1'b1;
            prev = uo_out[0];
        end
        check("pwm_rise_seen", 32'(found), 32'h1);
        hi = 0;
        while (uo_out[0] && hi < 5000) begin
            @(negedge clk);
            hi++;
        end
        lo = 0;
        while (!uo_out[0] && lo < 5000) begin
            @(negedge clk);
            lo++;
        end
        check_range("pwm_high_clks", hi, 1651, 1677);
        check("pwm_period_clks", 32'(hi + lo), 32'd3328);
        check("pwm_other_ch", 32'({uio_out, uo_out[7:1]}), 32'h0);

        // Duty extremes with PWM enabled
        spi_frame(16'h8400, 16);
        cnt = 0;
        for (int i = 0; i < 3400; i++) begin
            @(negedge clk);
            if (uo_out[0]) cnt++;
        end
        check("duty00_high_clks", 32'(cnt), 32'd0);
        spi_frame(16'h84FF, 16);
        cnt = 0;
        for (int i = 0; i < 3400; i++) begin
            @(negedge clk);
            if (!uo_out[0]) cnt++;
        end
        check("dutyFF_low_clks", 32'(cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
